// File: rtl/reg_trace_bank.sv
// Trace register bank: indexed rule window, shadowed pattern/mask with atomic
// commit, saturating per-rule match counters with coherent multi-byte reads.
// Ports: usb_clk/reset_n, reg_* front-end bus, read_data, selected,
// I_synchronized, I_match, O_* trigger controls, live patterns/masks, O_commit.
module reg_trace_bank #(
  parameter int pADDR_WIDTH = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pMATCH_RULES = 8,
  parameter int pBUFFER_SIZE = 64,
  parameter int pCOUNT_WIDTH = 16,
  parameter logic [1:0] pSELECT = 2'b10
) (
  input  logic usb_clk,
  input  logic reset_n,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic [7:0] write_data,
  output logic [7:0] read_data,
  input  logic reg_read,
  input  logic reg_write,
  input  logic reg_addrvalid,
  output logic selected,
  input  logic I_synchronized,
  input  logic [pMATCH_RULES-1:0] I_match,
  output logic [4:0] O_clksettings,
  output logic [pMATCH_RULES-1:0] O_pattern_enable,
  output logic [pMATCH_RULES-1:0] O_pattern_trig_enable,
  output logic O_trace_reset_sync,
  output logic [2:0] O_trace_width,
  output logic O_soft_trig_passthru,
  output logic O_soft_trig_enable,
  output logic O_capture_raw,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_trace_pattern,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_trace_mask,
  output logic O_commit
);

  localparam int NR = pMATCH_RULES;
  localparam int BW = pBUFFER_SIZE;
  localparam int NB = BW / 8;
  localparam int CW = pCOUNT_WIDTH;
  localparam int NC = CW / 8;
  localparam int PW = NR * BW;
  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;

  // "TraceRg2", byte 0 in the low byte
  localparam logic [63:0] NAME = 64'h3267_5265_6361_7254;

  localparam logic [4:0] A_NAME  = 5'h00;
  localparam logic [4:0] A_REV   = 5'h01;
  localparam logic [4:0] A_CLK   = 5'h02;
  localparam logic [4:0] A_PEN   = 5'h03;
  localparam logic [4:0] A_PTE   = 5'h04;
  localparam logic [4:0] A_RSYNC = 5'h05;
  localparam logic [4:0] A_WIDTH = 5'h06;
  localparam logic [4:0] A_PASS  = 5'h07;
  localparam logic [4:0] A_STEN  = 5'h08;
  localparam logic [4:0] A_RAW   = 5'h09;
  localparam logic [4:0] A_SYNC  = 5'h0A;
  localparam logic [4:0] A_RSEL  = 5'h0B;
  localparam logic [4:0] A_PAT   = 5'h0C;
  localparam logic [4:0] A_MSK   = 5'h0D;
  localparam logic [4:0] A_COMM  = 5'h0E;
  localparam logic [4:0] A_CNT   = 5'h0F;
  localparam logic [4:0] A_CLR   = 5'h10;

  logic [4:0] r_clk;
  logic [NR-1:0] r_pen;
  logic [NR-1:0] r_pte;
  logic r_rsync;
  logic [2:0] r_width;
  logic r_pass;
  logic r_sten;
  logic r_raw;
  logic [3:0] r_sel;
  logic [PW-1:0] r_sh_pat;
  logic [PW-1:0] r_sh_msk;
  logic [PW-1:0] r_pat;
  logic [PW-1:0] r_msk;
  logic r_dirty;
  logic r_commit;
  logic [CW-1:0] r_cnt [NR];
  logic [CW-1:0] r_snap;
  logic [7:0] r_rdata;

  logic [4:0] w_addr;
  logic [31:0] w_bidx;
  logic w_b0;
  logic w_wr;
  logic w_rd;
  logic w_clr;
  logic [7:0] w_rbyte;
  logic [CW-1:0] w_cnt_sel;
  logic w_unused;

  assign w_addr = reg_address[4:0];
  assign w_bidx = 32'(reg_bytecnt);
  assign w_b0 = (reg_bytecnt == '0);
  assign selected = reg_addrvalid & (reg_address[6:5] == pSELECT);
  assign w_wr = selected & reg_write;
  assign w_rd = selected & reg_read;
  assign w_clr = w_wr & (w_addr == A_CLR) & w_b0 & write_data[0];
  // snapshot byte 0 is never read back: byte 0 always comes from the live count
  assign w_unused = &{1'b0, reg_address[AW-1:7], r_snap[7:0]};

  assign read_data = r_rdata;
  assign O_clksettings = r_clk;
  assign O_pattern_enable = r_pen;
  assign O_pattern_trig_enable = r_pte;
  assign O_trace_reset_sync = r_rsync;
  assign O_trace_width = r_width;
  assign O_soft_trig_passthru = r_pass;
  assign O_soft_trig_enable = r_sten;
  assign O_capture_raw = r_raw;
  assign O_trace_pattern = r_pat;
  assign O_trace_mask = r_msk;
  assign O_commit = r_commit;

  always_comb begin
    w_cnt_sel = '0;
    for (int r = 0; r < NR; r++)
      if (r_sel == 4'(r)) w_cnt_sel = r_cnt[r];
  end

  always_comb begin
    w_rbyte = 8'h00;
    case (w_addr)
      A_NAME:
        for (int b = 0; b < 8; b++)
          if (w_bidx == 32'(b)) w_rbyte = NAME[b*8 +: 8];
      A_REV:   if (w_b0) w_rbyte = 8'h01;
      A_CLK:   if (w_b0) w_rbyte = {3'b000, r_clk};
      A_PEN:
        for (int k = 0; k < NR; k++)
          if (w_bidx == 32'(k / 8)) w_rbyte[k % 8] = r_pen[k];
      A_PTE:
        for (int k = 0; k < NR; k++)
          if (w_bidx == 32'(k / 8)) w_rbyte[k % 8] = r_pte[k];
      A_RSYNC: if (w_b0) w_rbyte = {7'd0, r_rsync};
      A_WIDTH: if (w_b0) w_rbyte = {5'd0, r_width};
      A_PASS:  if (w_b0) w_rbyte = {7'd0, r_pass};
      A_STEN:  if (w_b0) w_rbyte = {7'd0, r_sten};
      A_RAW:   if (w_b0) w_rbyte = {7'd0, r_raw};
      A_SYNC:  if (w_b0) w_rbyte = {7'd0, I_synchronized};
      A_RSEL:  if (w_b0) w_rbyte = {4'd0, r_sel};
      A_PAT:
        for (int r = 0; r < NR; r++)
          for (int b = 0; b < NB; b++)
            if (r_sel == 4'(r) && w_bidx == 32'(b))
              w_rbyte = r_sh_pat[r*BW + b*8 +: 8];
      A_MSK:
        for (int r = 0; r < NR; r++)
          for (int b = 0; b < NB; b++)
            if (r_sel == 4'(r) && w_bidx == 32'(b))
              w_rbyte = r_sh_msk[r*BW + b*8 +: 8];
      A_COMM:  if (w_b0) w_rbyte = {7'd0, r_dirty};
      A_CNT: begin
        if (w_b0) w_rbyte = w_cnt_sel[7:0];
        for (int b = 1; b < NC; b++)
          if (w_bidx == 32'(b)) w_rbyte = r_snap[b*8 +: 8];
      end
      default: w_rbyte = 8'h00;
    endcase
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk <= '0;
      r_pen <= '0;
      r_pte <= '0;
      r_rsync <= 1'b0;
      r_width <= 3'd4;
      r_pass <= 1'b1;
      r_sten <= 1'b0;
      r_raw <= 1'b0;
      r_sel <= '0;
      r_sh_pat <= '0;
      r_sh_msk <= '1;
      r_pat <= '0;
      r_msk <= '1;
      r_dirty <= 1'b0;
      r_commit <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      if (w_wr) begin
        case (w_addr)
          A_CLK:   if (w_b0) r_clk <= write_data[4:0];
          A_PEN:
            for (int k = 0; k < NR; k++)
              if (w_bidx == 32'(k / 8)) r_pen[k] <= write_data[k % 8];
          A_PTE:
            for (int k = 0; k < NR; k++)
              if (w_bidx == 32'(k / 8)) r_pte[k] <= write_data[k % 8];
          A_RSYNC: if (w_b0) r_rsync <= write_data[0];
          A_WIDTH: if (w_b0) r_width <= write_data[2:0];
          A_PASS:  if (w_b0) r_pass <= write_data[0];
          A_STEN:  if (w_b0) r_sten <= write_data[0];
          A_RAW:   if (w_b0) r_raw <= write_data[0];
          A_RSEL:
            if (w_b0 && 32'(write_data) < 32'(NR))
              r_sel <= write_data[3:0];
          A_PAT:
            if (w_bidx < 32'(NB)) begin
              r_dirty <= 1'b1;
              for (int r = 0; r < NR; r++)
                for (int b = 0; b < NB; b++)
                  if (r_sel == 4'(r) && w_bidx == 32'(b))
                    r_sh_pat[r*BW + b*8 +: 8] <= write_data;
            end
          A_MSK:
            if (w_bidx < 32'(NB)) begin
              r_dirty <= 1'b1;
              for (int r = 0; r < NR; r++)
                for (int b = 0; b < NB; b++)
                  if (r_sel == 4'(r) && w_bidx == 32'(b))
                    r_sh_msk[r*BW + b*8 +: 8] <= write_data;
            end
          A_COMM:
            if (w_b0) begin
              r_pat <= r_sh_pat;
              r_msk <= r_sh_msk;
              r_dirty <= 1'b0;
              r_commit <= 1'b1;
            end
          default: ;
        endcase
      end
    end
  end

  // clear has priority over a coincident match
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (w_clr)
          r_cnt[i] <= '0;
        else if (I_match[i] && r_cnt[i] != {CW{1'b1}})
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  // byte-0 read of MATCH_COUNT freezes the count for the upper bytes
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap <= '0;
      r_rdata <= 8'h00;
    end else begin
      r_rdata <= w_rd ? w_rbyte : 8'h00;
      if (w_rd && w_addr == A_CNT && w_b0) r_snap <= w_cnt_sel;
    end
  end

endmodule

// File: tb/tb_reg_trace_bank.sv
// Self-checking bench for reg_trace_bank: vector table, corner sequences,
// randomized traffic against a byte-array model, and a 12-rule/32-bit instance.
module tb_reg_trace_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [13:0] addr;
  logic [6:0] bc;
  logic [7:0] wd;
  logic rd_s, wr_s, av1, av2, sync_i;
  logic [7:0] m1;
  logic [11:0] m2;

  logic [7:0] rdata1, rdata2;
  logic sel1, sel2;
  logic [4:0] clk1, clk2;
  logic [7:0] pen1, pte1;
  logic [11:0] pen2, pte2;
  logic rsync1, rsync2, pass1, pass2, sten1, sten2, raw1, raw2;
  logic [2:0] width1, width2;
  logic [511:0] pat1, msk1;
  logic [383:0] pat2, msk2;
  logic com1, com2;

  reg_trace_bank dut1 (
    .usb_clk(clk), .reset_n(rst_n), .reg_address(addr),
    .reg_bytecnt(bc), .write_data(wd), .read_data(rdata1),
    .reg_read(rd_s), .reg_write(wr_s), .reg_addrvalid(av1),
    .selected(sel1), .I_synchronized(sync_i), .I_match(m1),
    .O_clksettings(clk1), .O_pattern_enable(pen1),
    .O_pattern_trig_enable(pte1), .O_trace_reset_sync(rsync1),
    .O_trace_width(width1), .O_soft_trig_passthru(pass1),
    .O_soft_trig_enable(sten1), .O_capture_raw(raw1),
    .O_trace_pattern(pat1), .O_trace_mask(msk1), .O_commit(com1)
  );

  reg_trace_bank #(.pMATCH_RULES(12), .pBUFFER_SIZE(32)) dut2 (
    .usb_clk(clk), .reset_n(rst_n), .reg_address(addr),
    .reg_bytecnt(bc), .write_data(wd), .read_data(rdata2),
    .reg_read(rd_s), .reg_write(wr_s), .reg_addrvalid(av2),
    .selected(sel2), .I_synchronized(sync_i), .I_match(m2),
    .O_clksettings(clk2), .O_pattern_enable(pen2),
    .O_pattern_trig_enable(pte2), .O_trace_reset_sync(rsync2),
    .O_trace_width(width2), .O_soft_trig_passthru(pass2),
    .O_soft_trig_enable(sten2), .O_capture_raw(raw2),
    .O_trace_pattern(pat2), .O_trace_mask(msk2), .O_commit(com2)
  );

  int checks = 0;
  int errors = 0;
  int tgt = 0;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input int b, input logic [7:0] d);
    @(negedge clk);
    addr = 14'({2'b10, a});
    bc = 7'(b);
    wd = d;
    wr_s = 1'b1;
    av1 = (tgt == 0);
    av2 = (tgt == 1);
    @(negedge clk);
    wr_s = 1'b0;
    av1 = 1'b0;
    av2 = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input int b, output logic [7:0] d);
    @(negedge clk);
    addr = 14'({2'b10, a});
    bc = 7'(b);
    rd_s = 1'b1;
    av1 = (tgt == 0);
    av2 = (tgt == 1);
    @(negedge clk);
    rd_s = 1'b0;
    av1 = 1'b0;
    av2 = 1'b0;
    d = (tgt == 1) ? rdata2 : rdata1;
  endtask

  task automatic hold_match(input int n);
    @(negedge clk);
    m1 = 8'h04;
    repeat (n) @(negedge clk);
    m1 = 8'h00;
  endtask

  typedef struct {
    logic [4:0] a;
    int b;
    bit w;
    logic [7:0] wd;
    logic [7:0] exp;
    string nm;
  } vec_t;

  // reference model for dut1
  bit [63:0] sp[8], sm[8], lp[8], lm[8];
  int cnt[8];
  int snap, msel;
  bit dirty;

  function automatic logic [511:0] live_pat();
    logic [511:0] v = '0;
    for (int r = 0; r < 8; r++) v[r*64 +: 64] = lp[r];
    return v;
  endfunction

  function automatic logic [511:0] live_msk();
    logic [511:0] v = '0;
    for (int r = 0; r < 8; r++) v[r*64 +: 64] = lm[r];
    return v;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[$];
    logic [7:0] got;
    logic [511:0] e;
    string nm_s;
    nm_s = "TraceRg2";
    rst_n = 1'b0;
    addr = '0; bc = '0; wd = '0;
    rd_s = 0; wr_s = 0; av1 = 0; av2 = 0;
    sync_i = 1'b1;
    m1 = '0; m2 = '0;
    repeat (3) @(negedge clk);
    chk("rst pattern", pat1, '0);
    chk("rst mask", msk1, {512{1'b1}});
    chk("rst commit", 512'(com1), 512'(0));
    chk("rst width", 512'(width1), 512'(4));
    chk("rst passthru", 512'(pass1), 512'(1));
    chk("rst rdata", 512'(rdata1), 512'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      tv.push_back('{5'h00, i, 0, 8'h00, nm_s[i], "name"});
    tv.push_back('{5'h00, 8, 0, 8'h00, 8'h00, "name b8"});
    tv.push_back('{5'h01, 0, 0, 8'h00, 8'h01, "rev"});
    tv.push_back('{5'h06, 0, 0, 8'h00, 8'h04, "width rst"});
    tv.push_back('{5'h07, 0, 0, 8'h00, 8'h01, "pass rst"});
    tv.push_back('{5'h08, 0, 0, 8'h00, 8'h00, "sten rst"});
    tv.push_back('{5'h0D, 0, 0, 8'h00, 8'hFF, "mask b0"});
    tv.push_back('{5'h0D, 7, 0, 8'h00, 8'hFF, "mask b7"});
    tv.push_back('{5'h0D, 8, 0, 8'h00, 8'h00, "mask b8"});
    tv.push_back('{5'h0E, 0, 0, 8'h00, 8'h00, "dirty rst"});
    tv.push_back('{5'h0B, 0, 0, 8'h00, 8'h00, "rsel rst"});
    tv.push_back('{5'h1F, 0, 0, 8'h00, 8'h00, "unmapped"});
    tv.push_back('{5'h0A, 0, 0, 8'h00, 8'h01, "sync"});
    tv.push_back('{5'h02, 0, 1, 8'hFF, 8'h1F, "clk wr"});
    tv.push_back('{5'h06, 0, 1, 8'hFF, 8'h07, "width wr"});
    tv.push_back('{5'h03, 0, 1, 8'hA5, 8'hA5, "pen b0"});
    tv.push_back('{5'h03, 1, 1, 8'hFF, 8'h00, "pen b1"});
    tv.push_back('{5'h09, 0, 1, 8'h03, 8'h01, "raw wr"});
    tv.push_back('{5'h0B, 0, 1, 8'h05, 8'h05, "rsel 5"});
    tv.push_back('{5'h0B, 0, 1, 8'h08, 8'h05, "rsel 8"});
    tv.push_back('{5'h01, 0, 1, 8'h55, 8'h01, "rev wr"});
    tv.push_back('{5'h02, 1, 1, 8'h00, 8'h00, "clk b1"});

    foreach (tv[i]) begin
      if (tv[i].w) wr(tv[i].a, tv[i].b, tv[i].wd);
      rd(tv[i].a, tv[i].b, got);
      chk(tv[i].nm, 512'(got), 512'(tv[i].exp));
    end
    @(negedge clk);
    chk("rdata idle", 512'(rdata1), 512'(0));
    chk("clk out", 512'(clk1), 512'(5'h1F));
    chk("width out", 512'(width1), 512'(7));
    chk("pen out", 512'(pen1), 512'(8'hA5));
    chk("raw out", 512'(raw1), 512'(1));

    // shadow/commit
    wr(5'h0B, 0, 8'h03);
    for (int b = 0; b < 8; b++) wr(5'h0C, b, 8'(8'h11 * (b + 1)));
    chk("pat pre-commit", pat1, '0);
    rd(5'h0E, 0, got);
    chk("dirty set", 512'(got), 512'(1));
    wr(5'h0E, 0, 8'h00);
    e = '0;
    e[3*64 +: 64] = 64'h8877665544332211;
    chk("commit pulse", 512'(com1), 512'(1));
    chk("commit pat", pat1, e);
    chk("commit mask", msk1, {512{1'b1}});
    @(negedge clk);
    chk("commit 1cyc", 512'(com1), 512'(0));
    rd(5'h0E, 0, got);
    chk("dirty clr", 512'(got), 512'(0));
    wr(5'h0B, 0, 8'h09);
    rd(5'h0B, 0, got);
    chk("rsel bound", 512'(got), 512'(3));

    // snapshot coherence
    wr(5'h0B, 0, 8'h02);
    hold_match(255);
    rd(5'h0F, 0, got);
    chk("snap b0", 512'(got), 512'(8'hFF));
    hold_match(1);
    rd(5'h0F, 1, got);
    chk("snap b1", 512'(got), 512'(8'h00));
    rd(5'h0F, 0, got);
    chk("snap b0 again", 512'(got), 512'(8'h00));
    rd(5'h0F, 1, got);
    chk("snap b1 again", 512'(got), 512'(8'h01));

    // saturation, then clear racing a match
    hold_match(70000);
    rd(5'h0F, 0, got);
    chk("sat b0", 512'(got), 512'(8'hFF));
    rd(5'h0F, 1, got);
    chk("sat b1", 512'(got), 512'(8'hFF));
    rd(5'h0F, 2, got);
    chk("cnt b2", 512'(got), 512'(8'h00));
    @(negedge clk);
    addr = 14'({2'b10, 5'h10}); bc = '0; wd = 8'h01;
    wr_s = 1'b1; av1 = 1'b1; m1 = 8'h04;
    @(negedge clk);
    wr_s = 1'b0; av1 = 1'b0; m1 = 8'h00;
    rd(5'h0F, 0, got);
    chk("clr b0", 512'(got), 512'(0));
    rd(5'h0F, 1, got);
    chk("clr b1", 512'(got), 512'(0));

    // reset while a commit write is on the bus
    wr(5'h0C, 0, 8'hAA);
    @(negedge clk);
    addr = 14'({2'b10, 5'h0E}); bc = '0; wd = 8'h00;
    wr_s = 1'b1; av1 = 1'b1;
    #2 rst_n = 1'b0;
    #1 wr_s = 1'b0; av1 = 1'b0;
    @(negedge clk);
    chk("abort pat", pat1, '0);
    chk("abort commit", 512'(com1), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rd(5'h0E, 0, got);
    chk("abort dirty", 512'(got), 512'(0));
    rd(5'h0B, 0, got);
    chk("abort rsel", 512'(got), 512'(0));

    // randomized traffic against the model
    for (int r = 0; r < 8; r++) begin
      sp[r] = '0; sm[r] = '1; lp[r] = '0; lm[r] = '1; cnt[r] = 0;
    end
    snap = 0; msel = 0; dirty = 0;
    for (int it = 0; it < 400; it++) begin
      int op, v, b;
      logic [7:0] d, mv;
      logic [4:0] a;
      logic [7:0] ex;
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          v = $urandom_range(0, 11);
          wr(5'h0B, 0, 8'(v));
          if (v < 8) msel = v;
        end
        1, 2: begin
          b = $urandom_range(0, 9);
          d = 8'($urandom);
          wr(op == 1 ? 5'h0C : 5'h0D, b, d);
          if (b < 8) begin
            if (op == 1) sp[msel][b*8 +: 8] = d;
            else sm[msel][b*8 +: 8] = d;
            dirty = 1;
          end
        end
        3: begin
          wr(5'h0E, 0, 8'($urandom));
          for (int r = 0; r < 8; r++) begin
            lp[r] = sp[r]; lm[r] = sm[r];
          end
          dirty = 0;
          chk("rnd pulse", 512'(com1), 512'(1));
          chk("rnd pat", pat1, live_pat());
          chk("rnd mask", msk1, live_msk());
        end
        4: begin
          mv = 8'($urandom);
          @(negedge clk);
          m1 = mv;
          @(negedge clk);
          m1 = 8'h00;
          for (int r = 0; r < 8; r++)
            if (mv[r] && cnt[r] < 65535) cnt[r]++;
        end
        default: begin
          v = $urandom_range(0, 4);
          a = 5'(5'h0B + v);
          b = $urandom_range(0, 9);
          rd(a, b, got);
          ex = 8'h00;
          case (a)
            5'h0B: if (b == 0) ex = 8'(msel);
            5'h0C: if (b < 8) ex = sp[msel][b*8 +: 8];
            5'h0D: if (b < 8) ex = sm[msel][b*8 +: 8];
            5'h0E: if (b == 0) ex = 8'(dirty);
            default: begin
              if (b == 0) begin
                snap = cnt[msel];
                ex = 8'(cnt[msel] % 256);
              end else if (b == 1) begin
                ex = 8'(snap / 256);
              end
            end
          endcase
          chk("rnd read", 512'(got), 512'(ex));
        end
      endcase
    end

    // 12 rules, 32-bit patterns
    tgt = 1;
    chk("p2 rst mask", 512'(msk2), 512'({384{1'b1}}));
    wr(5'h03, 0, 8'hFF);
    wr(5'h03, 1, 8'hFF);
    rd(5'h03, 1, got);
    chk("p2 pen b1", 512'(got), 512'(8'h0F));
    rd(5'h03, 2, got);
    chk("p2 pen b2", 512'(got), 512'(0));
    chk("p2 pen out", 512'(pen2), 512'(12'hFFF));
    wr(5'h0B, 0, 8'd11);
    wr(5'h0C, 0, 8'hDE);
    wr(5'h0C, 1, 8'hAD);
    wr(5'h0C, 2, 8'hBE);
    wr(5'h0C, 3, 8'hEF);
    wr(5'h0C, 4, 8'h55);
    rd(5'h0C, 4, got);
    chk("p2 pat b4", 512'(got), 512'(0));
    wr(5'h0E, 0, 8'h01);
    e = '0;
    e[383:352] = 32'hEFBEADDE;
    chk("p2 commit", 512'(pat2), e);
    chk("p2 pulse", 512'(com2), 512'(1));
    chk("p2 dut1 quiet", pat1, live_pat());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
